// File: rtl/hpdcache_pkg.sv
// -----------------------------------------------------------------------------
// hpdcache_pkg
// Shared types and constants for the refill acknowledge path.
//   - HPDCACHE_* localparams : default geometry used by the refill block
//   - hpdcache_refill_beats  : number of memory beats per cache line
//   - hpdcache_refill_line_t : flattened line buffer (word 0 in LSBs)
//   - hpdcache_refill_state_e: refill FSM states
//   - hpdcache_core_rsp_t    : core response {tid, sid, data, error}
// -----------------------------------------------------------------------------
package hpdcache_pkg;

   localparam int unsigned HPDCACHE_WORD_WIDTH = 64;
   localparam int unsigned HPDCACHE_LINE_WORDS = 8;
   localparam int unsigned HPDCACHE_BEAT_WORDS = 2;
   localparam int unsigned HPDCACHE_TID_WIDTH  = 6;
   localparam int unsigned HPDCACHE_SID_WIDTH  = 3;

   function automatic int unsigned hpdcache_refill_beats(input int unsigned line_words,
                                                         input int unsigned beat_words);
      return line_words / beat_words;
   endfunction

   localparam int unsigned HPDCACHE_REFILL_BEATS =
      hpdcache_refill_beats(HPDCACHE_LINE_WORDS, HPDCACHE_BEAT_WORDS);

   typedef logic [HPDCACHE_LINE_WORDS*HPDCACHE_WORD_WIDTH-1:0] hpdcache_refill_line_t;

   typedef enum logic [1:0] {
      REFILL_COLLECT,
      REFILL_ACK,
      REFILL_CAPTURE,
      REFILL_ISSUE
   } hpdcache_refill_state_e;

   typedef struct packed {
      logic [HPDCACHE_TID_WIDTH-1:0]  tid;
      logic [HPDCACHE_SID_WIDTH-1:0]  sid;
      logic [HPDCACHE_WORD_WIDTH-1:0] data;
      logic                           error;
   } hpdcache_core_rsp_t;

endpackage

// File: rtl/hpdcache_refill_linebuf.sv
// -----------------------------------------------------------------------------
// hpdcache_refill_linebuf
// Line buffer for memory refill beats with its own beat counter.
//   clk_i, rst_i   : clock, synchronous active-high reset (clears counter+data)
//   wr_i           : accepted beat, written at the current beat slot
//   wr_last_i      : final beat of the line, counter returns to 0
//   wr_data_i      : beat data, word 0 in LSBs
//   beat_cnt_o     : index of the next beat slot to be written
//   rd_word_i      : word index for the single-word read port
//   rd_data_o      : selected word
//   line_o         : whole line, word 0 in LSBs
// -----------------------------------------------------------------------------
module hpdcache_refill_linebuf #(
   parameter  int unsigned WORD_WIDTH = 64,
   parameter  int unsigned LINE_WORDS = 8,
   parameter  int unsigned BEAT_WORDS = 2,
   localparam int unsigned BEATS      = LINE_WORDS / BEAT_WORDS,
   localparam int unsigned BEAT_BITS  = BEAT_WORDS * WORD_WIDTH,
   localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1,
   localparam int unsigned WIDX_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             wr_i,
   input  logic                             wr_last_i,
   input  logic [BEAT_BITS-1:0]             wr_data_i,
   output logic [CNT_W-1:0]                 beat_cnt_o,
   input  logic [WIDX_W-1:0]                rd_word_i,
   output logic [WORD_WIDTH-1:0]            rd_data_o,
   output logic [LINE_WORDS*WORD_WIDTH-1:0] line_o
);

   logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic [BEAT_BITS-1:0] beat_q [BEATS];
   logic [WORD_WIDTH-1:0] words [LINE_WORDS];

   // A last beat always realigns the counter so a malformed line cannot
   // leave the next one starting mid-buffer.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (wr_i) begin
         if (wr_last_i || (beat_cnt_q == CNT_W'(BEATS - 1))) begin
            beat_cnt_d = '0;
         end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         beat_cnt_q <= '0;
         for (int b = 0; b < int'(BEATS); b++) begin
            beat_q[b] <= '0;
         end
      end else begin
         beat_cnt_q <= beat_cnt_d;
         if (wr_i) begin
            beat_q[beat_cnt_q] <= wr_data_i;
         end
      end
   end

   for (genvar b = 0; b < BEATS; b++) begin : g_beat
      assign line_o[b*BEAT_BITS +: BEAT_BITS] = beat_q[b];
   end

   for (genvar w = 0; w < LINE_WORDS; w++) begin : g_word
      assign words[w] = line_o[w*WORD_WIDTH +: WORD_WIDTH];
   end

   assign rd_data_o  = words[rd_word_i];
   assign beat_cnt_o = beat_cnt_q;

endmodule

// File: rtl/hpdcache_refill_ack.sv
// -----------------------------------------------------------------------------
// hpdcache_refill_ack
// Refill-side companion of the MSHR: gathers multi-beat memory read responses
// into a line buffer, acknowledges the owning MSHR entry, captures the entry
// fields returned one cycle later, then issues the cache refill write and,
// when the entry needs it, the core response carrying the requested word.
//
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   mem_rsp_*             : memory read-response beats (valid/ready, {way,set}
//                           id, data with word 0 in LSBs, last, error)
//   ack_o/ack_cs_o        : one-cycle acknowledge to the MSHR, set/way from id
//   ack_*_i               : MSHR entry fields, valid the cycle after ack_o
//   refill_*              : cache line write request (valid/ready, nline, data)
//   core_rsp_*            : core response (valid/ready, tid, sid, data, error)
//   busy_o                : not idle in COLLECT or a line partially received
//
// Optional feature, macro HPDCACHE_REFILL_ERROR_EN: beat errors accumulate over
// the line; an erroneous line is not written to the cache and its response
// carries error=1. Without the macro errors are ignored and error_o is 0.
// -----------------------------------------------------------------------------
module hpdcache_refill_ack
   import hpdcache_pkg::*;
#(
   parameter int unsigned MSHR_SET_WIDTH = 4,
   parameter int unsigned MSHR_WAY_WIDTH = 2,
   parameter int unsigned NLINE_WIDTH    = 34,
   parameter int unsigned TID_WIDTH      = HPDCACHE_TID_WIDTH,
   parameter int unsigned SID_WIDTH      = HPDCACHE_SID_WIDTH,
   parameter int unsigned WORD_WIDTH     = HPDCACHE_WORD_WIDTH,
   parameter int unsigned LINE_WORDS     = HPDCACHE_LINE_WORDS,
   parameter int unsigned BEAT_WORDS     = HPDCACHE_BEAT_WORDS,
   localparam int unsigned ID_W   = MSHR_WAY_WIDTH + MSHR_SET_WIDTH,
   localparam int unsigned BEATS  = hpdcache_refill_beats(LINE_WORDS, BEAT_WORDS),
   localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1,
   localparam int unsigned WIDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             mem_rsp_valid_i,
   output logic                             mem_rsp_ready_o,
   input  logic [ID_W-1:0]                  mem_rsp_id_i,
   input  logic [BEAT_WORDS*WORD_WIDTH-1:0] mem_rsp_data_i,
   input  logic                             mem_rsp_last_i,
   input  logic                             mem_rsp_error_i,
   output logic                             ack_o,
   output logic                             ack_cs_o,
   output logic [MSHR_SET_WIDTH-1:0]        ack_set_o,
   output logic [MSHR_WAY_WIDTH-1:0]        ack_way_o,
   input  logic [TID_WIDTH-1:0]             ack_req_id_i,
   input  logic [SID_WIDTH-1:0]             ack_src_id_i,
   input  logic [NLINE_WIDTH-1:0]           ack_nline_i,
   input  logic [WIDX_W-1:0]                ack_word_i,
   input  logic                             ack_need_rsp_i,
   input  logic                             ack_is_prefetch_i,
   output logic                             refill_valid_o,
   input  logic                             refill_ready_i,
   output logic [NLINE_WIDTH-1:0]           refill_nline_o,
   output logic [LINE_WORDS*WORD_WIDTH-1:0] refill_data_o,
   output logic                             core_rsp_valid_o,
   input  logic                             core_rsp_ready_i,
   output logic [TID_WIDTH-1:0]             core_rsp_tid_o,
   output logic [SID_WIDTH-1:0]             core_rsp_sid_o,
   output logic [WORD_WIDTH-1:0]            core_rsp_data_o,
   output logic                             core_rsp_error_o,
   output logic                             busy_o
);

   hpdcache_refill_state_e  state_q, state_d;
   logic [ID_W-1:0]         id_q, id_d;
   logic                    refill_pend_q, refill_pend_d;
   logic                    rsp_pend_q, rsp_pend_d;
   logic [TID_WIDTH-1:0]    tid_q, tid_d;
   logic [SID_WIDTH-1:0]    sid_q, sid_d;
   logic [NLINE_WIDTH-1:0]  nline_q, nline_d;
   logic [WIDX_W-1:0]       word_q, word_d;
   logic                    err_q;
   logic                    beat_acc;
   logic [CNT_W-1:0]        beat_cnt;
   logic [WORD_WIDTH-1:0]   rd_word;
   hpdcache_core_rsp_t      core_rsp;

   assign mem_rsp_ready_o = (state_q == REFILL_COLLECT);
   assign beat_acc        = mem_rsp_valid_i & mem_rsp_ready_o;

   hpdcache_refill_linebuf #(
      .WORD_WIDTH (WORD_WIDTH),
      .LINE_WORDS (LINE_WORDS),
      .BEAT_WORDS (BEAT_WORDS)
   ) i_linebuf (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_i       (beat_acc),
      .wr_last_i  (mem_rsp_last_i),
      .wr_data_i  (mem_rsp_data_i),
      .beat_cnt_o (beat_cnt),
      .rd_word_i  (word_q),
      .rd_data_o  (rd_word),
      .line_o     (refill_data_o)
   );

   always_comb begin
      state_d       = state_q;
      id_d          = id_q;
      refill_pend_d = refill_pend_q;
      rsp_pend_d    = rsp_pend_q;
      tid_d         = tid_q;
      sid_d         = sid_q;
      nline_d       = nline_q;
      word_d        = word_q;
      case (state_q)
         REFILL_COLLECT: begin
            if (beat_acc) begin
               if (beat_cnt == '0) begin
                  id_d = mem_rsp_id_i;
               end
               if (mem_rsp_last_i) begin
                  state_d = REFILL_ACK;
               end
            end
         end
         REFILL_ACK: begin
            state_d = REFILL_CAPTURE;
         end
         // MSHR entry fields arrive here, one cycle after the ack
         REFILL_CAPTURE: begin
            tid_d         = ack_req_id_i;
            sid_d         = ack_src_id_i;
            nline_d       = ack_nline_i;
            word_d        = ack_word_i;
            rsp_pend_d    = ack_need_rsp_i & ~ack_is_prefetch_i;
            refill_pend_d = ~err_q;
            state_d       = REFILL_ISSUE;
         end
         REFILL_ISSUE: begin
            if (refill_pend_q && refill_ready_i) begin
               refill_pend_d = 1'b0;
            end
            if (rsp_pend_q && core_rsp_ready_i) begin
               rsp_pend_d = 1'b0;
            end
            if (!refill_pend_d && !rsp_pend_d) begin
               state_d = REFILL_COLLECT;
            end
         end
         default: begin
            state_d = REFILL_COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= REFILL_COLLECT;
         refill_pend_q <= 1'b0;
         rsp_pend_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         refill_pend_q <= refill_pend_d;
         rsp_pend_q    <= rsp_pend_d;
      end
   end

   always_ff @(posedge clk_i) begin
      id_q    <= id_d;
      tid_q   <= tid_d;
      sid_q   <= sid_d;
      nline_q <= nline_d;
      word_q  <= word_d;
   end

`ifdef HPDCACHE_REFILL_ERROR_EN
   logic err_d;

   // The first beat restarts accumulation so a line never inherits a stale flag.
   always_comb begin
      err_d = err_q;
      if ((state_q == REFILL_ISSUE) && (state_d == REFILL_COLLECT)) begin
         err_d = 1'b0;
      end else if (beat_acc) begin
         err_d = ((beat_cnt == '0) ? 1'b0 : err_q) | mem_rsp_error_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   logic unused_err;
   assign err_q      = 1'b0;
   assign unused_err = mem_rsp_error_i;
`endif

   assign ack_o     = (state_q == REFILL_ACK);
   assign ack_cs_o  = (state_q == REFILL_ACK);
   assign ack_set_o = id_q[MSHR_SET_WIDTH-1:0];
   assign ack_way_o = id_q[ID_W-1:MSHR_SET_WIDTH];

   assign refill_valid_o = refill_pend_q;
   assign refill_nline_o = nline_q;

   assign core_rsp.tid   = tid_q;
   assign core_rsp.sid   = sid_q;
   assign core_rsp.data  = rd_word;
   assign core_rsp.error = err_q;

   assign core_rsp_valid_o = rsp_pend_q;
   assign core_rsp_tid_o   = core_rsp.tid;
   assign core_rsp_sid_o   = core_rsp.sid;
   assign core_rsp_data_o  = core_rsp.data;
   assign core_rsp_error_o = core_rsp.error;

   assign busy_o = (state_q != REFILL_COLLECT) || (beat_cnt != '0);

`ifndef SYNTHESIS
   a_last_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
      beat_acc |-> (mem_rsp_last_i == (beat_cnt == CNT_W'(BEATS - 1))));
   a_id_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (beat_acc && (beat_cnt != '0)) |-> (mem_rsp_id_i == id_q));
   a_ack_single: assert property (@(posedge clk_i) disable iff (rst_i)
      ack_o |=> !ack_o);
`endif

endmodule

// File: tb/tb_hpdcache_refill_ack.sv
module tb_hpdcache_refill_ack;

   localparam int SETW = 4;
   localparam int WAYW = 2;
   localparam int NLW  = 34;
   localparam int TIDW = 6;
   localparam int SIDW = 3;
   localparam int WW   = 64;
   localparam int LW   = 8;
   localparam int BW   = 2;
   localparam int NB   = LW / BW;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 mem_rsp_valid;
   logic                 mem_rsp_ready;
   logic [WAYW+SETW-1:0] mem_rsp_id;
   logic [BW*WW-1:0]     mem_rsp_data;
   logic                 mem_rsp_last;
   logic                 mem_rsp_error;
   logic                 ack, ack_cs;
   logic [SETW-1:0]      ack_set;
   logic [WAYW-1:0]      ack_way;
   logic [TIDW-1:0]      ack_req_id;
   logic [SIDW-1:0]      ack_src_id;
   logic [NLW-1:0]       ack_nline;
   logic [2:0]           ack_word;
   logic                 ack_need_rsp, ack_is_prefetch;
   logic                 refill_valid, refill_ready;
   logic [NLW-1:0]       refill_nline;
   logic [LW*WW-1:0]     refill_data;
   logic                 core_rsp_valid, core_rsp_ready;
   logic [TIDW-1:0]      core_rsp_tid;
   logic [SIDW-1:0]      core_rsp_sid;
   logic [WW-1:0]        core_rsp_data;
   logic                 core_rsp_error;
   logic                 busy;

   always #5 clk = ~clk;

   hpdcache_refill_ack dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .mem_rsp_valid_i   (mem_rsp_valid),
      .mem_rsp_ready_o   (mem_rsp_ready),
      .mem_rsp_id_i      (mem_rsp_id),
      .mem_rsp_data_i    (mem_rsp_data),
      .mem_rsp_last_i    (mem_rsp_last),
      .mem_rsp_error_i   (mem_rsp_error),
      .ack_o             (ack),
      .ack_cs_o          (ack_cs),
      .ack_set_o         (ack_set),
      .ack_way_o         (ack_way),
      .ack_req_id_i      (ack_req_id),
      .ack_src_id_i      (ack_src_id),
      .ack_nline_i       (ack_nline),
      .ack_word_i        (ack_word),
      .ack_need_rsp_i    (ack_need_rsp),
      .ack_is_prefetch_i (ack_is_prefetch),
      .refill_valid_o    (refill_valid),
      .refill_ready_i    (refill_ready),
      .refill_nline_o    (refill_nline),
      .refill_data_o     (refill_data),
      .core_rsp_valid_o  (core_rsp_valid),
      .core_rsp_ready_i  (core_rsp_ready),
      .core_rsp_tid_o    (core_rsp_tid),
      .core_rsp_sid_o    (core_rsp_sid),
      .core_rsp_data_o   (core_rsp_data),
      .core_rsp_error_o  (core_rsp_error),
      .busy_o            (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   // current line as the memory and MSHR models see it
   logic [WAYW+SETW-1:0] cur_id;
   logic [WW-1:0]        cur_w [LW];
   logic [NB-1:0]        cur_err;
   logic [TIDW-1:0]      cur_tid;
   logic [SIDW-1:0]      cur_sid;
   logic [NLW-1:0]       cur_nline;
   logic [2:0]           cur_word;
   logic                 cur_need, cur_pf;
   bit                   no_gap;

   task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_line();
      cur_id    = 6'($urandom);
      for (int w = 0; w < LW; w++) cur_w[w] = {$urandom, $urandom};
      cur_err   = '0;
      cur_tid   = 6'($urandom);
      cur_sid   = 3'($urandom);
      cur_nline = {2'($urandom), $urandom};
      cur_word  = 3'($urandom);
      cur_need  = 1'($urandom);
      cur_pf    = 1'($urandom);
   endtask

   task automatic send_beat(input int b);
      mem_rsp_valid = 1'b1;
      mem_rsp_id    = cur_id;
      mem_rsp_data  = {cur_w[2*b+1], cur_w[2*b]};
      mem_rsp_last  = (b == NB - 1);
      mem_rsp_error = cur_err[b];
      check_eq("mem_ready_collect", mem_rsp_ready, 1);
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_last  = 1'b0;
      mem_rsp_error = 1'b0;
   endtask

   // rmode 0: random readies, 1: both ready, 2: refill held off 5 cycles
   task automatic run_line(input int rmode);
      logic [511:0] exp_line;
      bit any_err, exp_ref, exp_rsp, rr, cr;
      int cyc;
      for (int b = 0; b < NB; b++) begin
         if (!no_gap) begin
            repeat ($urandom_range(0, 2)) begin
               check_eq("ack_idle", ack, 0);
               tick();
            end
         end
         send_beat(b);
      end
      check_eq("ack", ack, 1);
      check_eq("ack_cs", ack_cs, 1);
      check_eq("ack_set", ack_set, cur_id[SETW-1:0]);
      check_eq("ack_way", ack_way, cur_id[WAYW+SETW-1:SETW]);
      check_eq("mem_ready_ack", mem_rsp_ready, 0);
      ack_req_id      = cur_tid;
      ack_src_id      = cur_sid;
      ack_nline       = cur_nline;
      ack_word        = cur_word;
      ack_need_rsp    = cur_need;
      ack_is_prefetch = cur_pf;
      tick();
      check_eq("ack_once", ack, 0);
      check_eq("refill_early", refill_valid, 0);
      check_eq("rsp_early", core_rsp_valid, 0);
      tick();
      // entry fields must have been captured; scramble the MSHR outputs
      ack_req_id = 6'($urandom); ack_src_id = 3'($urandom); ack_nline = {2'($urandom), $urandom};
      ack_word = 3'($urandom); ack_need_rsp = 1'($urandom); ack_is_prefetch = 1'($urandom);

      any_err = 1'b0;
`ifdef HPDCACHE_REFILL_ERROR_EN
      any_err = |cur_err;
`endif
      exp_ref = !any_err;
      exp_rsp = cur_need && !cur_pf;
      exp_line = '0;
      for (int w = 0; w < LW; w++) exp_line[w*WW +: WW] = cur_w[w];
      cyc = 0;
      do begin
         check_eq("refill_valid", refill_valid, exp_ref);
         check_eq("rsp_valid", core_rsp_valid, exp_rsp);
         check_eq("mem_ready_issue", mem_rsp_ready, 0);
         check_eq("busy_issue", busy, 1);
         if (exp_ref) begin
            check_eq("refill_nline", refill_nline, cur_nline);
            check_eq("refill_data", refill_data, exp_line);
         end
         if (exp_rsp) begin
            check_eq("rsp_tid", core_rsp_tid, cur_tid);
            check_eq("rsp_sid", core_rsp_sid, cur_sid);
            check_eq("rsp_data", core_rsp_data, cur_w[cur_word]);
            check_eq("rsp_error", core_rsp_error, any_err);
         end
         case (rmode)
            1: begin rr = 1'b1; cr = 1'b1; end
            2: begin rr = (cyc >= 5); cr = 1'b1; end
            default: begin rr = 1'($urandom); cr = 1'($urandom); end
         endcase
         refill_ready   = rr;
         core_rsp_ready = cr;
         tick();
         cyc++;
         if (rr) exp_ref = 1'b0;
         if (cr) exp_rsp = 1'b0;
      end while ((exp_ref || exp_rsp) && cyc < 200);
      if (exp_ref || exp_rsp) check_eq("issue_timeout", 1, 0);
      refill_ready   = 1'b0;
      core_rsp_ready = 1'b0;
      check_eq("back_to_collect", mem_rsp_ready, 1);
      check_eq("idle_busy", busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      mem_rsp_valid = 0; mem_rsp_id = '0; mem_rsp_data = '0; mem_rsp_last = 0; mem_rsp_error = 0;
      ack_req_id = '0; ack_src_id = '0; ack_nline = '0; ack_word = '0;
      ack_need_rsp = 0; ack_is_prefetch = 0; refill_ready = 0; core_rsp_ready = 0;
      no_gap = 1'b0;
      repeat (3) tick();
      check_eq("rst_ack", ack, 0);
      check_eq("rst_ack_cs", ack_cs, 0);
      check_eq("rst_refill_valid", refill_valid, 0);
      check_eq("rst_rsp_valid", core_rsp_valid, 0);
      check_eq("rst_mem_ready", mem_rsp_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_refill_data", refill_data, 0);
      rst = 1'b0;
      tick();

      // directed: way 2 / set 5, word 3 with a core response
      rand_line();
      cur_id = {2'd2, 4'd5}; cur_need = 1; cur_pf = 0; cur_word = 3'd3;
      run_line(1);

      // prefetch: refill only
      rand_line();
      cur_need = 1; cur_pf = 1;
      run_line(1);

      // refill held off while the core response completes first
      rand_line();
      cur_need = 1; cur_pf = 0;
      run_line(2);

      // reset after two beats drops the partial line
      rand_line();
      send_beat(0);
      send_beat(1);
      check_eq("partial_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("reset_mid_busy", busy, 0);
      check_eq("reset_mid_ack", ack, 0);
      check_eq("reset_mid_ready", mem_rsp_ready, 1);
      tick();
      check_eq("reset_mid_noack", ack, 0);
      rand_line();
      run_line(0);

      // back-to-back lines with no idle cycles
      no_gap = 1'b1;
      rand_line();
      run_line(1);
      rand_line();
      run_line(1);
      no_gap = 1'b0;

      // error on beat 1
      rand_line();
      cur_need = 1; cur_pf = 0; cur_err = 4'b0010;
      run_line(0);

      // a clean line right after an errored one
      rand_line();
      cur_need = 1; cur_pf = 0;
      run_line(0);

      // randomized lines
      for (int n = 0; n < 40; n++) begin
         rand_line();
         no_gap = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 4) == 0) cur_err = 4'($urandom);
         run_line(($urandom_range(0, 3) == 0) ? 1 : 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/hpdcache_refill_ack.md
Name: hpdcache_refill_ack

Overview:
- Refill-side counterpart of the MSHR. Collects multi-beat memory read responses into a line buffer, then acknowledges the owning MSHR entry (ack port).
- Captures the entry fields the MSHR returns one cycle later, then issues a cache refill write and, when required, a core response carrying the requested word.
- Sits between the memory read-response channel, the MSHR ack interface and the cache data/response arbiters.

Parameters:
- MSHR_SET_WIDTH, 4, MSHR set index width
- MSHR_WAY_WIDTH, 2, MSHR way index width
- NLINE_WIDTH, 34, cache line number width
- TID_WIDTH, 6, core request transaction id width
- SID_WIDTH, 3, core request source id width
- WORD_WIDTH, 64, data word width
- LINE_WORDS, 8, words per cache line (power of 2)
- BEAT_WORDS, 2, words per memory beat (power of 2, divides LINE_WORDS)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- mem_rsp_valid_i  in  1  memory response beat valid
- mem_rsp_ready_o  out  1  beat accepted when valid&ready
- mem_rsp_id_i  in  MSHR_WAY_WIDTH+MSHR_SET_WIDTH  {way,set} of owning MSHR entry
- mem_rsp_data_i  in  BEAT_WORDS*WORD_WIDTH  beat data, word 0 in LSBs
- mem_rsp_last_i  in  1  final beat of line
- mem_rsp_error_i  in  1  beat error (used only with the optional feature)
- ack_o  out  1  drives MSHR ack_i
- ack_cs_o  out  1  drives MSHR ack_cs_i
- ack_set_o  out  MSHR_SET_WIDTH  MSHR ack set
- ack_way_o  out  MSHR_WAY_WIDTH  MSHR ack way
- ack_req_id_i  in  TID_WIDTH  MSHR entry req id, valid cycle after ack
- ack_src_id_i  in  SID_WIDTH  MSHR entry source id
- ack_nline_i  in  NLINE_WIDTH  MSHR entry line number
- ack_word_i  in  log2(LINE_WORDS)  requested word index
- ack_need_rsp_i  in  1  core response required
- ack_is_prefetch_i  in  1  prefetch entry
- refill_valid_o  out  1  cache line write request
- refill_ready_i  in  1  write accepted
- refill_nline_o  out  NLINE_WIDTH  line number
- refill_data_o  out  LINE_WORDS*WORD_WIDTH  line data
- core_rsp_valid_o  out  1  core response valid
- core_rsp_ready_i  in  1  core response accepted
- core_rsp_tid_o  out  TID_WIDTH  transaction id
- core_rsp_sid_o  out  SID_WIDTH  source id
- core_rsp_data_o  out  WORD_WIDTH  requested word
- core_rsp_error_o  out  1  error flag (0 without the optional feature)
- busy_o  out  1  state != IDLE or beat_cnt != 0

Behaviour:
- FSM states: COLLECT, ACK, CAPTURE, ISSUE. Reset: COLLECT, beat_cnt=0, all valid/ack outputs 0, mem_rsp_ready_o=1, buffers 0.
- COLLECT: mem_rsp_ready_o=1. Each accepted beat writes buffer words [beat_cnt*BEAT_WORDS +: BEAT_WORDS]. The first beat (beat_cnt==0) latches id. beat_cnt increments modulo LINE_WORDS/BEAT_WORDS.
- COLLECT, accepted beat with last=1: beat_cnt->0, go to ACK. last must coincide with beat_cnt==max; a mismatch or an id change mid-line is an assertion error.
- ACK: ack_o=ack_cs_o=1 for exactly one cycle; set/way from latched id. mem_rsp_ready_o=0 in every non-COLLECT state. Go to CAPTURE.
- CAPTURE: register ack_* inputs (1-cycle MSHR read latency). Set rsp_pend = need_rsp & ~is_prefetch. Set refill_pend=1. Go to ISSUE.
- ISSUE: refill_valid_o=refill_pend; core_rsp_valid_o=rsp_pend. Each pend clears on its own handshake; the two may complete in the same or different cycles, in either order.
- ISSUE: when both pends are clear (including in the cycle they clear), go to COLLECT. A new beat is accepted the next cycle at the earliest.
- Outputs and valid stay stable while valid&!ready.
- core_rsp_data_o = buffer word ack_word (captured).
- Single-beat config (BEAT_WORDS==LINE_WORDS): every beat must have last=1.
- Reset mid-operation: return to COLLECT; discard partial line; no ack; pends cleared. Assertion: ack_o never asserted in two consecutive cycles.

Optional Feature:
- Macro: HPDCACHE_REFILL_ERROR_EN.
- Defined: mem_rsp_error_i is OR-accumulated over the line into err_q. If err_q=1, refill_pend is never set (no cache write), and core_rsp_error_o=err_q whenever a response is issued. err_q clears on entering COLLECT.
- Undefined: mem_rsp_error_i is ignored, core_rsp_error_o is tied 0, and a refill is always issued.

Decomposition:
- hpdcache_pkg: refill beat count constant, line buffer typedef, FSM state enum, and a core response struct {tid,sid,data,error}.
- Sub-module hpdcache_refill_linebuf: beat-indexed write, word-indexed read, plus beat counter.

Test Plan:
- 4 beats, id {way 2,set 5}, need_rsp=1, word 3 -> ack_o 1 cycle with set 5/way 2; refill and core_rsp valid 2 cycles after ack; core data = word 3.
- Prefetch entry (is_prefetch=1) -> refill only; core_rsp_valid_o stays 0; back to COLLECT after refill handshake.
- refill_ready_i low 5 cycles, core_rsp_ready_i high -> core rsp completes first; refill held stable; mem_rsp_ready_o=0 until refill accepted.
- rst_i asserted after beat 2 -> no ack, busy_o=0 next cycle; a new 4-beat line completes correctly.
- Back-to-back lines, both readies high -> second line's first beat accepted the cycle after ISSUE exits; no beat lost.
- With HPDCACHE_REFILL_ERROR_EN, error on beat 1 -> no refill, core_rsp_error_o=1; without the macro -> refill issued, error_o=0.
